// File: rtl/rf_1p_arb_if.sv
// Requester-side bundle for rf_1p_arb.
// One instance per requester (A or B).
//   req_i    : access request, held until gnt_o is seen
//   wen_i    : write enable, low active (0 = write, 1 = read)
//   addr_i   : RF address
//   data_i   : RF write data
//   gnt_o    : granted this cycle (combinational)
//   rvalid_o : one-cycle pulse, rdata_o just updated with a read result
//   rdata_o  : last read result, held until the next read of this requester completes
// The master modport is the requesting stage; the slave modport is the arbiter.
interface rf_1p_arb_if #(
  parameter int Word_Width = 32,
  parameter int Addr_Width = 8
);
  logic                  req_i;
  logic                  wen_i;
  logic [Addr_Width-1:0] addr_i;
  logic [Word_Width-1:0] data_i;
  logic                  gnt_o;
  logic                  rvalid_o;
  logic [Word_Width-1:0] rdata_o;

  modport master (
    output req_i, wen_i, addr_i, data_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, wen_i, addr_i, data_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/rf_1p_arb.sv
// Two-requester arbiter / sequencer in front of a single-port register file
// (low-active cen/wen, read data valid one cycle after the access).
// At most one access is granted per cycle; read data is steered back to the
// requester that issued the read and held there.
// Ports:
//   clk, rst_n  : RF clock, asynchronous active-low reset
//   a, b        : requester bundles (rf_1p_arb_if.slave)
//   rf_cen_o    : RF chip enable, low active
//   rf_wen_o    : RF write enable, low active
//   rf_addr_o   : RF address
//   rf_data_o   : RF write data
//   rf_data_i   : RF read data, only meaningful the cycle after a read access
// PRIO_MODE = 0 round-robin, 1 fixed priority with A winning.
module rf_1p_arb #(
  parameter int Word_Width = 32,
  parameter int Addr_Width = 8,
  parameter int PRIO_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rf_1p_arb_if.slave            a,
  rf_1p_arb_if.slave            b,
  output logic                  rf_cen_o,
  output logic                  rf_wen_o,
  output logic [Addr_Width-1:0] rf_addr_o,
  output logic [Word_Width-1:0] rf_data_o,
  input  logic [Word_Width-1:0] rf_data_i
);

  typedef enum logic {
    ID_A = 1'b0,
    ID_B = 1'b1
  } req_id_e;

  req_id_e               last_r;
  logic                  a_gnt;
  logic                  b_gnt;
  logic                  pend_a_p1;
  logic                  pend_b_p1;
  logic                  a_rvalid_p2;
  logic                  b_rvalid_p2;
  logic [Word_Width-1:0] a_rdata_p2;
  logic [Word_Width-1:0] b_rdata_p2;

  // Stage p0: grant and RF port drive (combinational)
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (a.req_i && b.req_i) begin
      // On contention A wins in fixed-priority mode, or when B had the last grant.
      if (PRIO_MODE == 1 || last_r == ID_B) begin
        a_gnt = 1'b1;
      end else begin
        b_gnt = 1'b1;
      end
    end else begin
      a_gnt = a.req_i;
      b_gnt = b.req_i;
    end
  end

  always_comb begin
    // Idle cycles drive a defined, inactive port so no X reaches the macro.
    rf_cen_o  = 1'b1;
    rf_wen_o  = 1'b1;
    rf_addr_o = '0;
    rf_data_o = '0;
    if (a_gnt) begin
      rf_cen_o  = 1'b0;
      rf_wen_o  = a.wen_i;
      rf_addr_o = a.addr_i;
      rf_data_o = a.data_i;
    end else if (b_gnt) begin
      rf_cen_o  = 1'b0;
      rf_wen_o  = b.wen_i;
      rf_addr_o = b.addr_i;
      rf_data_o = b.data_i;
    end
  end

  // Stage p1: remember which requester owns the data the RF returns next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r    <= ID_B;
      pend_a_p1 <= 1'b0;
      pend_b_p1 <= 1'b0;
    end else begin
      if (a_gnt) begin
        last_r <= ID_A;
      end else if (b_gnt) begin
        last_r <= ID_B;
      end
      pend_a_p1 <= a_gnt & a.wen_i;
      pend_b_p1 <= b_gnt & b.wen_i;
    end
  end

  // Stage p2: capture RF read data into the owning requester's held register.
  // rf_data_i is only looked at when a read is pending, so its idle-cycle
  // garbage never reaches either output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid_p2 <= 1'b0;
      b_rvalid_p2 <= 1'b0;
      a_rdata_p2  <= '0;
      b_rdata_p2  <= '0;
    end else begin
      a_rvalid_p2 <= pend_a_p1;
      b_rvalid_p2 <= pend_b_p1;
      if (pend_a_p1) begin
        a_rdata_p2 <= rf_data_i;
      end
      if (pend_b_p1) begin
        b_rdata_p2 <= rf_data_i;
      end
    end
  end

  assign a.gnt_o    = a_gnt;
  assign b.gnt_o    = b_gnt;
  assign a.rvalid_o = a_rvalid_p2;
  assign b.rvalid_o = b_rvalid_p2;
  assign a.rdata_o  = a_rdata_p2;
  assign b.rdata_o  = b_rdata_p2;

endmodule

// File: tb/tb_rf_1p_arb.sv
// Bench for rf_1p_arb: two instances (round-robin and fixed priority), each
// with its own register-file model, driven by directed and random requests.
// A reference model (shadow memory + due-cycle calendar) predicts every
// output each cycle.
module tb_rf_1p_arb;

  logic clk;
  logic rst_n;

  // [dut][requester] ; requester 0 = A, 1 = B ; dut 0 = PRIO_MODE 0, dut 1 = PRIO_MODE 1
  logic        req  [2][2];
  logic        wen  [2][2];
  logic [7:0]  addr [2][2];
  logic [31:0] wdat [2][2];
  logic        gnt  [2][2];
  logic        rv   [2][2];
  logic [31:0] rdat [2][2];

  logic        cen   [2];
  logic        rwen  [2];
  logic [7:0]  raddr [2];
  logic [31:0] rdo   [2];
  logic [31:0] rdi   [2];

  // register-file models
  logic [31:0] mem   [2][256];
  logic [31:0] rdq   [2];
  logic        rdv   [2];
  logic [31:0] junk  [2];
  logic        rf_ready;

  // reference model state
  logic [31:0] shadow [2][256];
  int          m_last [2];
  logic        ev     [2][2][4];
  logic [31:0] ed     [2][2][4];
  logic [31:0] m_rdata[2][2];
  logic        gseen  [2][2];
  int          cyc;
  int          w;
  int          slot;
  logic        erv;

  int vectors;
  int miscompares;

  rf_1p_arb_if #(.Word_Width(32), .Addr_Width(8)) ia0 ();
  rf_1p_arb_if #(.Word_Width(32), .Addr_Width(8)) ib0 ();
  rf_1p_arb_if #(.Word_Width(32), .Addr_Width(8)) ia1 ();
  rf_1p_arb_if #(.Word_Width(32), .Addr_Width(8)) ib1 ();

  assign ia0.req_i = req[0][0], ia0.wen_i = wen[0][0], ia0.addr_i = addr[0][0], ia0.data_i = wdat[0][0];
  assign ib0.req_i = req[0][1], ib0.wen_i = wen[0][1], ib0.addr_i = addr[0][1], ib0.data_i = wdat[0][1];
  assign ia1.req_i = req[1][0], ia1.wen_i = wen[1][0], ia1.addr_i = addr[1][0], ia1.data_i = wdat[1][0];
  assign ib1.req_i = req[1][1], ib1.wen_i = wen[1][1], ib1.addr_i = addr[1][1], ib1.data_i = wdat[1][1];
  assign gnt[0][0] = ia0.gnt_o, rv[0][0] = ia0.rvalid_o, rdat[0][0] = ia0.rdata_o;
  assign gnt[0][1] = ib0.gnt_o, rv[0][1] = ib0.rvalid_o, rdat[0][1] = ib0.rdata_o;
  assign gnt[1][0] = ia1.gnt_o, rv[1][0] = ia1.rvalid_o, rdat[1][0] = ia1.rdata_o;
  assign gnt[1][1] = ib1.gnt_o, rv[1][1] = ib1.rvalid_o, rdat[1][1] = ib1.rdata_o;
  assign rdi[0] = rdv[0] ? rdq[0] : junk[0];
  assign rdi[1] = rdv[1] ? rdq[1] : junk[1];

  rf_1p_arb #(.Word_Width(32), .Addr_Width(8), .PRIO_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .a(ia0), .b(ib0),
    .rf_cen_o(cen[0]), .rf_wen_o(rwen[0]), .rf_addr_o(raddr[0]),
    .rf_data_o(rdo[0]), .rf_data_i(rdi[0])
  );

  rf_1p_arb #(.Word_Width(32), .Addr_Width(8), .PRIO_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(ia1), .b(ib1),
    .rf_cen_o(cen[1]), .rf_wen_o(rwen[1]), .rf_addr_o(raddr[1]),
    .rf_data_o(rdo[1]), .rf_data_i(rdi[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int a);
    if (a == 5) return 32'h0000_1234;
    return 32'hA500_0000 | (32'(a) * 32'h0001_0101);
  endfunction

  // Register-file models: read data appears the cycle after the access; on
  // every other cycle the data output carries random junk.
  always @(posedge clk) begin
    if (!rf_ready) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 256; i++) mem[d][i] <= init_val(i);
      rf_ready <= 1'b1;
    end
    for (int d = 0; d < 2; d++) begin
      junk[d] <= $urandom;
      rdv[d]  <= !cen[d] && rwen[d];
      if (!cen[d]) begin
        if (!rwen[d]) mem[d][raddr[d]] <= rdo[d];
        else          rdq[d] <= mem[d][raddr[d]];
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  // Reference model and per-cycle comparison.
  always @(negedge clk) begin
    if (cyc == 0) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 256; i++) shadow[d][i] = init_val(i);
    end
    slot = cyc % 4;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_last[d] = 1;
        for (int r = 0; r < 2; r++) begin
          m_rdata[d][r] = 32'h0;
          for (int s = 0; s < 4; s++) ev[d][r][s] = 1'b0;
        end
      end
      // winner: -1 none, 0 A, 1 B
      if (req[d][0] && req[d][1]) w = (d == 1 || m_last[d] == 1) ? 0 : 1;
      else if (req[d][0])         w = 0;
      else if (req[d][1])         w = 1;
      else                        w = -1;

      chk($sformatf("gnt_a_d%0d", d), 64'(gnt[d][0]), 64'(w == 0));
      chk($sformatf("gnt_b_d%0d", d), 64'(gnt[d][1]), 64'(w == 1));
      chk($sformatf("cen_d%0d", d),   64'(cen[d]),    64'(w < 0));
      chk($sformatf("wen_d%0d", d),   64'(rwen[d]),   64'((w < 0) ? 1'b1 : wen[d][w]));
      chk($sformatf("addr_d%0d", d),  64'(raddr[d]),  64'((w < 0) ? 8'h0 : addr[d][w]));
      chk($sformatf("wdata_d%0d", d), 64'(rdo[d]),    64'((w < 0) ? 32'h0 : wdat[d][w]));

      for (int r = 0; r < 2; r++) begin
        erv = rst_n && ev[d][r][slot];
        if (erv) m_rdata[d][r] = ed[d][r][slot];
        ev[d][r][slot] = 1'b0;
        chk($sformatf("rvalid_d%0d_r%0d", d, r), 64'(rv[d][r]),   64'(erv));
        chk($sformatf("rdata_d%0d_r%0d", d, r),  64'(rdat[d][r]), 64'(m_rdata[d][r]));
        gseen[d][r] = gnt[d][r];
      end

      if (rst_n && w >= 0) begin
        m_last[d] = w;
        if (!wen[d][w]) begin
          shadow[d][addr[d][w]] = wdat[d][w];
        end else begin
          ev[d][w][(cyc + 2) % 4] = 1'b1;
          ed[d][w][(cyc + 2) % 4] = shadow[d][addr[d][w]];
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  task automatic put(input int d, input int r, input logic rq, input logic wn,
                     input logic [7:0] ad, input logic [31:0] dt);
    req[d][r]  = rq;
    wen[d][r]  = wn;
    addr[d][r] = ad;
    wdat[d][r] = dt;
  endtask

  int na, nb;

  initial begin
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    rf_ready = 1'b0;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 2; r++) begin
        put(d, r, 1'b0, 1'b1, 8'h0, 32'h0);
        gseen[d][r] = 1'b0;
      end

    // reset values
    repeat (2) tick();
    nedge();
    for (int d = 0; d < 2; d++) begin
      chk("rst_a_rvalid", 64'(rv[d][0]), 64'(0));
      chk("rst_b_rvalid", 64'(rv[d][1]), 64'(0));
      chk("rst_a_rdata",  64'(rdat[d][0]), 64'(0));
      chk("rst_b_rdata",  64'(rdat[d][1]), 64'(0));
    end

    // 1: A writes 0x10 then reads it back
    tick(); rst_n = 1'b1;
    put(0, 0, 1'b1, 1'b0, 8'h10, 32'hDEAD_BEEF);
    nedge();
    chk("t1_wr_gnt",  64'(gnt[0][0]), 64'(1));
    chk("t1_wr_cen",  64'(cen[0]),    64'(0));
    chk("t1_wr_wen",  64'(rwen[0]),   64'(0));
    chk("t1_wr_addr", 64'(raddr[0]),  64'(8'h10));
    tick(); put(0, 0, 1'b1, 1'b1, 8'h10, 32'h0);
    nedge(); chk("t1_rd_gnt", 64'(gnt[0][0]), 64'(1));
    tick(); put(0, 0, 1'b0, 1'b1, 8'h0, 32'h0);
    nedge(); chk("t1_rv_t1", 64'(rv[0][0]), 64'(0));
    tick();
    nedge();
    chk("t1_rv_t2",   64'(rv[0][0]),   64'(1));
    chk("t1_rdata",   64'(rdat[0][0]), 64'(32'hDEAD_BEEF));
    chk("t1_b_rv",    64'(rv[0][1]),   64'(0));

    // 2: continuous contention, round-robin
    tick(); rst_n = 1'b0;
    nedge();
    tick(); rst_n = 1'b1;
    put(0, 0, 1'b1, 1'b1, 8'h10, 32'h0);
    put(0, 1, 1'b1, 1'b1, 8'h20, 32'h0);
    na = 0; nb = 0;
    for (int i = 0; i < 10; i++) begin
      nedge();
      if (i < 8) begin
        chk($sformatf("t2_gnt_a_%0d", i), 64'(gnt[0][0]), 64'(i % 2 == 0));
        chk($sformatf("t2_gnt_b_%0d", i), 64'(gnt[0][1]), 64'(i % 2 == 1));
      end
      na += int'(rv[0][0]);
      nb += int'(rv[0][1]);
      tick();
      if (i == 7) begin
        put(0, 0, 1'b0, 1'b1, 8'h0, 32'h0);
        put(0, 1, 1'b0, 1'b1, 8'h0, 32'h0);
      end
    end
    chk("t2_a_pulses", 64'(na), 64'(4));
    chk("t2_b_pulses", 64'(nb), 64'(4));
    chk("t2_a_rdata",  64'(rdat[0][0]), 64'(32'hDEAD_BEEF));
    chk("t2_b_rdata",  64'(rdat[0][1]), 64'(32'hA520_2020));

    // 3: continuous contention, fixed priority
    put(1, 0, 1'b1, 1'b1, 8'h03, 32'h0);
    put(1, 1, 1'b1, 1'b1, 8'h04, 32'h0);
    for (int i = 0; i < 8; i++) begin
      nedge();
      chk($sformatf("t3_gnt_a_%0d", i), 64'(gnt[1][0]), 64'(1));
      chk($sformatf("t3_gnt_b_%0d", i), 64'(gnt[1][1]), 64'(0));
      tick();
    end
    put(1, 0, 1'b0, 1'b1, 8'h0, 32'h0);
    nedge(); chk("t3_b_after_drop", 64'(gnt[1][1]), 64'(1));
    tick(); put(1, 1, 1'b0, 1'b1, 8'h0, 32'h0);

    // 4: read / write / read on the same address
    put(0, 1, 1'b1, 1'b1, 8'h05, 32'h0);
    nedge(); chk("t4_b_gnt", 64'(gnt[0][1]), 64'(1));
    tick(); put(0, 1, 1'b0, 1'b1, 8'h0, 32'h0);
    put(0, 0, 1'b1, 1'b0, 8'h05, 32'h0000_5678);
    nedge(); chk("t4_a_gnt", 64'(gnt[0][0]), 64'(1));
    tick(); put(0, 0, 1'b0, 1'b1, 8'h0, 32'h0);
    put(0, 1, 1'b1, 1'b1, 8'h05, 32'h0);
    nedge();
    chk("t4_rv1",    64'(rv[0][1]),   64'(1));
    chk("t4_rdata1", 64'(rdat[0][1]), 64'(32'h0000_1234));
    tick(); put(0, 1, 1'b0, 1'b1, 8'h0, 32'h0);
    nedge();
    chk("t4_hold_rv",    64'(rv[0][1]),   64'(0));
    chk("t4_hold_rdata", 64'(rdat[0][1]), 64'(32'h0000_1234));
    tick();
    nedge();
    chk("t4_rv2",    64'(rv[0][1]),   64'(1));
    chk("t4_rdata2", 64'(rdat[0][1]), 64'(32'h0000_5678));

    // 5: idle
    for (int i = 0; i < 10; i++) begin
      tick();
      nedge();
      chk("t5_cen",     64'(cen[0]),     64'(1));
      chk("t5_wen",     64'(rwen[0]),    64'(1));
      chk("t5_addr",    64'(raddr[0]),   64'(0));
      chk("t5_rv",      64'({rv[0][0], rv[0][1]}), 64'(0));
      chk("t5_a_rdata", 64'(rdat[0][0]), 64'(32'hDEAD_BEEF));
      chk("t5_b_rdata", 64'(rdat[0][1]), 64'(32'h0000_5678));
    end

    // 6: reset during an outstanding read
    tick(); put(0, 0, 1'b1, 1'b1, 8'h10, 32'h0);
    nedge(); chk("t6_gnt", 64'(gnt[0][0]), 64'(1));
    tick(); put(0, 0, 1'b0, 1'b1, 8'h0, 32'h0);
    #2 rst_n = 1'b0;
    nedge();
    chk("t6_rv_t1",    64'(rv[0][0]),   64'(0));
    chk("t6_rdata_t1", 64'(rdat[0][0]), 64'(0));
    tick();
    nedge();
    chk("t6_rv_t2",    64'(rv[0][0]),   64'(0));
    chk("t6_rdata_t2", 64'(rdat[0][0]), 64'(0));
    tick(); rst_n = 1'b1;
    put(0, 0, 1'b1, 1'b1, 8'h11, 32'h0);
    put(0, 1, 1'b1, 1'b1, 8'h12, 32'h0);
    nedge();
    chk("t6_first_a", 64'(gnt[0][0]), 64'(1));
    chk("t6_first_b", 64'(gnt[0][1]), 64'(0));
    tick();
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 2; r++) put(d, r, 1'b0, 1'b1, 8'h0, 32'h0);
    tick();

    // random traffic on both instances, requests held until granted
    for (int k = 0; k < 1500; k++) begin
      for (int d = 0; d < 2; d++)
        for (int r = 0; r < 2; r++) begin
          if (!req[d][r] || gseen[d][r]) begin
            if ($urandom_range(9) < 6)
              put(d, r, 1'b1, 1'($urandom_range(1)), 8'($urandom_range(7)), $urandom);
            else
              put(d, r, 1'b0, 1'b1, 8'h0, 32'h0);
          end else if ($urandom_range(19) == 0) begin
            put(d, r, 1'b0, 1'b1, 8'h0, 32'h0);
          end
        end
      tick();
    end
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 2; r++) put(d, r, 1'b0, 1'b1, 8'h0, 32'h0);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
